// File: rtl/ahb_master_sequencer.sv
// AHB-Lite master front end. Arbitrates between the fetch port and the
// load/store port, runs one transfer at a time through the address and data
// phases, and aligns/extends load data by func3.
//
// state | meaning
// IDLE  | bus idle; arbitrate pending requests, flag misaligned accesses
// ADDR  | address phase, NONSEQ held on the bus until hready
// DATA  | data phase, waiting for hready or the first error cycle
// ERR   | second cycle of the two-cycle error response
module ahb_master_sequencer #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_write,
    input  logic [2:0]  ls_func3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
    localparam logic [1:0] HT_IDLE    = 2'b00;
    localparam logic [1:0] HT_NONSEQ  = 2'b10;

    state_t      state, state_nxt;
    logic [3:0]  streak, streak_nxt;
    logic        own_if, own_if_nxt;
    logic [2:0]  func3_q, func3_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [1:0]  lane_q, lane_nxt;
    logic [2:0]  dfunc3_q, dfunc3_nxt;

    logic [1:0]  htrans_nxt;
    logic [31:0] haddr_nxt, hwdata_nxt;
    logic        hwrite_nxt;
    logic [2:0]  hsize_nxt;
    logic [3:0]  hprot_nxt;
    logic        if_done_nxt, if_err_nxt, ls_done_nxt, ls_err_nxt;
    logic [31:0] if_rdata_nxt, ls_rdata_nxt;

    logic        grant_if;
    logic [2:0]  ls_size;
    logic        ls_misaligned;
    logic        if_misaligned;
    logic [31:0] ls_wdata_lanes;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Fetch only wins when alone or when the data port has used up its streak.
    assign grant_if = if_req && (!ls_req || streak == STREAK_MAX);

    assign ls_size = (ls_func3[1:0] == 2'b00) ? 3'b000 :
                     (ls_func3[1:0] == 2'b01) ? 3'b001 : 3'b010;

    assign ls_misaligned = (ls_size == 3'b001 && ls_addr[0]) ||
                           (ls_size == 3'b010 && ls_addr[1:0] != 2'b00);
    assign if_misaligned = (if_addr[1:0] != 2'b00);

    // Replicate store data across all lanes so the slave can pick any lane.
    always_comb begin
        ls_wdata_lanes = ls_wdata;
        case (ls_size)
            3'b000:  ls_wdata_lanes = {4{ls_wdata[7:0]}};
            3'b001:  ls_wdata_lanes = {2{ls_wdata[15:0]}};
            default: ls_wdata_lanes = ls_wdata;
        endcase
    end

    // Select the addressed lane of the read data and extend it by func3.
    always_comb begin
        load_byte = hrdata[7:0];
        case (lane_q)
            2'd0: load_byte = hrdata[7:0];
            2'd1: load_byte = hrdata[15:8];
            2'd2: load_byte = hrdata[23:16];
            2'd3: load_byte = hrdata[31:24];
            default: load_byte = hrdata[7:0];
        endcase
        load_half = lane_q[1] ? hrdata[31:16] : hrdata[15:0];
        case (dfunc3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = hrdata;
        endcase
    end

    // Next-state and next-output decode; all bus and completion outputs are registered.
    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        own_if_nxt   = own_if;
        func3_nxt    = func3_q;
        wdata_nxt    = wdata_q;
        lane_nxt     = lane_q;
        dfunc3_nxt   = dfunc3_q;
        htrans_nxt   = HT_IDLE;
        haddr_nxt    = haddr;
        hwrite_nxt   = hwrite;
        hsize_nxt    = hsize;
        hprot_nxt    = hprot;
        hwdata_nxt   = 32'h0;
        if_done_nxt  = 1'b0;
        if_err_nxt   = 1'b0;
        if_rdata_nxt = 32'h0;
        ls_done_nxt  = 1'b0;
        ls_err_nxt   = 1'b0;
        ls_rdata_nxt = 32'h0;

        case (state)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    if (grant_if || !if_req) begin
                        streak_nxt = 4'd0;
                    end else begin
                        streak_nxt = streak + 4'd1;
                    end
                    if (grant_if) begin
                        if (if_misaligned) begin
                            if_done_nxt = 1'b1;
                            if_err_nxt  = 1'b1;
                        end else begin
                            state_nxt  = ST_ADDR;
                            htrans_nxt = HT_NONSEQ;
                            haddr_nxt  = if_addr;
                            hwrite_nxt = 1'b0;
                            hsize_nxt  = 3'b010;
                            hprot_nxt  = 4'b0000;
                            own_if_nxt = 1'b1;
                            func3_nxt  = 3'b010;
                            wdata_nxt  = 32'h0;
                        end
                    end else if (ls_misaligned) begin
                        ls_done_nxt = 1'b1;
                        ls_err_nxt  = 1'b1;
                    end else begin
                        state_nxt  = ST_ADDR;
                        htrans_nxt = HT_NONSEQ;
                        haddr_nxt  = ls_addr;
                        hwrite_nxt = ls_write;
                        hsize_nxt  = ls_size;
                        hprot_nxt  = 4'b0001;
                        own_if_nxt = 1'b0;
                        func3_nxt  = ls_func3;
                        wdata_nxt  = ls_write ? ls_wdata_lanes : 32'h0;
                    end
                end
            end
            ST_ADDR: begin
                htrans_nxt = HT_NONSEQ;
                if (hready) begin
                    state_nxt  = ST_DATA;
                    htrans_nxt = HT_IDLE;
                    hwdata_nxt = wdata_q;
                    lane_nxt   = haddr[1:0];
                    dfunc3_nxt = func3_q;
                end
            end
            ST_DATA: begin
                hwdata_nxt = hwdata;
                if (hresp) begin
                    if (hready) begin
                        state_nxt   = ST_IDLE;
                        hwdata_nxt  = 32'h0;
                        if_done_nxt = own_if;
                        if_err_nxt  = own_if;
                        ls_done_nxt = !own_if;
                        ls_err_nxt  = !own_if;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end else if (hready) begin
                    state_nxt  = ST_IDLE;
                    hwdata_nxt = 32'h0;
                    if (own_if) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = hrdata;
                    end else begin
                        ls_done_nxt  = 1'b1;
                        ls_rdata_nxt = load_data;
                    end
                end
            end
            ST_ERR: begin
                hwdata_nxt = hwdata;
                if (hready) begin
                    state_nxt   = ST_IDLE;
                    hwdata_nxt  = 32'h0;
                    if_done_nxt = own_if;
                    if_err_nxt  = own_if;
                    ls_done_nxt = !own_if;
                    ls_err_nxt  = !own_if;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            streak   <= 4'd0;
            own_if   <= 1'b0;
            func3_q  <= 3'b010;
            wdata_q  <= 32'h0;
            lane_q   <= 2'b00;
            dfunc3_q <= 3'b010;
            htrans   <= HT_IDLE;
            haddr    <= 32'h0;
            hwrite   <= 1'b0;
            hsize    <= 3'b010;
            hprot    <= 4'b0000;
            hwdata   <= 32'h0;
            if_done  <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= 32'h0;
            ls_done  <= 1'b0;
            ls_err   <= 1'b0;
            ls_rdata <= 32'h0;
        end else begin
            state    <= state_nxt;
            streak   <= streak_nxt;
            own_if   <= own_if_nxt;
            func3_q  <= func3_nxt;
            wdata_q  <= wdata_nxt;
            lane_q   <= lane_nxt;
            dfunc3_q <= dfunc3_nxt;
            htrans   <= htrans_nxt;
            haddr    <= haddr_nxt;
            hwrite   <= hwrite_nxt;
            hsize    <= hsize_nxt;
            hprot    <= hprot_nxt;
            hwdata   <= hwdata_nxt;
            if_done  <= if_done_nxt;
            if_err   <= if_err_nxt;
            if_rdata <= if_rdata_nxt;
            ls_done  <= ls_done_nxt;
            ls_err   <= ls_err_nxt;
            ls_rdata <= ls_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_master_sequencer.sv
// Bench for ahb_master_sequencer: directed bus scenarios, arbitration,
// reset, and randomized single transfers against a transaction-level model.
module tb_ahb_master_sequencer;

    localparam int MAXD = 4;

    logic        hclk;
    logic        hresetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_write;
    logic [2:0]  ls_func3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_tests;
    int n_fail;

    ahb_master_sequencer #(.MAX_DSTREAK(MAXD)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_err   (if_err),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_write (ls_write),
        .ls_func3 (ls_func3),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_err   (ls_err),
        .ls_rdata (ls_rdata),
        .htrans   (htrans),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hready   (hready),
        .hresp    (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 3'b000;
        if (f3 == 3'b001 || f3 == 3'b101) return 3'b001;
        return 3'b010;
    endfunction

    function automatic bit m_mis(input logic [2:0] sz, input logic [31:0] a);
        return (sz == 3'b001 && (a % 2) != 0) || (sz == 3'b010 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * (a % 4))) & 32'h0000_00FF;
        h = (d >> (8 * (a % 4))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            3'b000:  return (wd & 32'h0000_00FF) * 32'h0101_0101;
            3'b001:  return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One complete request on either port with the given slave behaviour.
    task automatic xfer(input bit is_if, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int aw, input int dw, input bit er, input string tag);
        logic [2:0] sz;
        bit         mis;
        sz  = is_if ? 3'b010 : m_size(f3);
        mis = m_mis(sz, addr);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            ls_req   = 1'b1;
            ls_write = wr;
            ls_func3 = f3;
            ls_addr  = addr;
            ls_wdata = wd;
        end
        hready = 1'b1;
        hresp  = 1'b0;
        @(negedge hclk);
        if (mis) begin
            chk({tag, "_mis_htrans"}, 32'(htrans), 32'h0);
            chk({tag, "_mis_doneerr"}, 32'(is_if ? {if_done, if_err} : {ls_done, ls_err}), 32'h3);
            chk({tag, "_mis_other"}, 32'(is_if ? ls_done : if_done), 32'h0);
            if_req = 1'b0;
            ls_req = 1'b0;
            @(negedge hclk);
            chk({tag, "_mis_after"}, 32'({if_done, ls_done, htrans}), 32'h0);
            return;
        end
        chk({tag, "_htrans_a"}, 32'(htrans), 32'h2);
        chk({tag, "_haddr"}, haddr, addr);
        chk({tag, "_hwrite"}, 32'(hwrite), 32'(wr & !is_if));
        chk({tag, "_hsize"}, 32'(hsize), 32'(sz));
        chk({tag, "_hprot"}, 32'(hprot), is_if ? 32'h0 : 32'h1);
        for (int i = 0; i < aw; i++) begin
            hready = 1'b0;
            @(negedge hclk);
            chk({tag, "_await_htrans"}, 32'(htrans), 32'h2);
            chk({tag, "_await_haddr"}, haddr, addr);
        end
        hready = 1'b1;
        @(negedge hclk);
        chk({tag, "_htrans_d"}, 32'(htrans), 32'h0);
        if (wr && !is_if) chk({tag, "_hwdata"}, hwdata, m_store(f3, wd));
        if (er) begin
            hresp  = 1'b1;
            hready = 1'b0;
            @(negedge hclk);
            chk({tag, "_err1"}, 32'({htrans, if_done, ls_done}), 32'h0);
            hready = 1'b1;
            @(negedge hclk);
            chk({tag, "_err2_htrans"}, 32'(htrans), 32'h0);
            chk({tag, "_err2_doneerr"}, 32'(is_if ? {if_done, if_err} : {ls_done, ls_err}), 32'h3);
            chk({tag, "_err2_rdata"}, is_if ? if_rdata : ls_rdata, 32'h0);
        end else begin
            for (int i = 0; i < dw; i++) begin
                hready = 1'b0;
                hrdata = $urandom;
                @(negedge hclk);
                chk({tag, "_dwait"}, 32'({htrans, if_done, ls_done}), 32'h0);
            end
            hready = 1'b1;
            hrdata = rd;
            @(negedge hclk);
            chk({tag, "_doneerr"}, 32'(is_if ? {if_done, if_err} : {ls_done, ls_err}), 32'h2);
            chk({tag, "_other"}, 32'(is_if ? ls_done : if_done), 32'h0);
            if (is_if) chk({tag, "_rdata"}, if_rdata, rd);
            else if (!wr) chk({tag, "_rdata"}, ls_rdata, m_load(f3, addr, rd));
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        hready = 1'b1;
        hresp  = 1'b0;
        @(negedge hclk);
        chk({tag, "_after"}, 32'({htrans, if_done, ls_done}), 32'h0);
        if (wr && !is_if) chk({tag, "_hwdata_after"}, hwdata, 32'h0);
    endtask

    int          g;
    bit          exp_if;
    bit          r_if;
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [2:0]  f3_tab [5];

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        f3_tab   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        hresetn  = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        ls_req   = 1'b0;
        ls_write = 1'b0;
        ls_func3 = 3'b010;
        ls_addr  = 32'h0;
        ls_wdata = 32'h0;
        hrdata   = 32'h0;
        hready   = 1'b1;
        hresp    = 1'b0;

        repeat (2) @(negedge hclk);
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hsize", 32'(hsize), 32'h2);
        chk("rst_misc", 32'({hwrite, hprot, if_done, if_err, ls_done, ls_err}), 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_rdata", if_rdata | ls_rdata, 32'h0);
        hresetn = 1'b1;
        @(negedge hclk);

        xfer(1'b0, 1'b0, 3'b010, 32'hB000_0004, 32'h0, 32'h1234_5678, 0, 0, 1'b0, "lw0");
        xfer(1'b0, 1'b0, 3'b000, 32'hB000_0003, 32'h0, 32'h8000_0000, 0, 2, 1'b0, "lb_wait");
        xfer(1'b0, 1'b0, 3'b100, 32'hB000_0003, 32'h0, 32'h8000_0000, 0, 2, 1'b0, "lbu_wait");
        xfer(1'b0, 1'b1, 3'b001, 32'hB000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0, "sh");
        xfer(1'b0, 1'b0, 3'b101, 32'hB000_0012, 32'h0, 32'h9ABC_1234, 2, 1, 1'b0, "lhu_await");
        xfer(1'b0, 1'b0, 3'b010, 32'hB000_0008, 32'h0, 32'h0, 0, 0, 1'b1, "err");
        xfer(1'b0, 1'b0, 3'b010, 32'hB000_0002, 32'h0, 32'h0, 0, 0, 1'b0, "mis_lw");
        xfer(1'b1, 1'b0, 3'b010, 32'hA000_0100, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0, "fetch");
        xfer(1'b1, 1'b0, 3'b010, 32'hA000_0102, 32'h0, 32'h0, 0, 0, 1'b0, "mis_fetch");

        // Both ports held: every (MAXD+1)-th grant must go to fetch.
        if_addr  = 32'hA000_0010;
        ls_addr  = 32'hB000_0020;
        ls_func3 = 3'b010;
        ls_write = 1'b0;
        hready   = 1'b1;
        hresp    = 1'b0;
        if_req   = 1'b1;
        ls_req   = 1'b1;
        g = 0;
        for (int c = 0; c < 60 && g < 10; c++) begin
            @(negedge hclk);
            chk("arb_excl", 32'(if_done & ls_done), 32'h0);
            if (htrans == 2'b10) begin
                exp_if = (g % (MAXD + 1)) == MAXD;
                chk("arb_hprot", 32'(hprot), exp_if ? 32'h0 : 32'h1);
                chk("arb_haddr", haddr, exp_if ? if_addr : ls_addr);
                g++;
            end
        end
        chk("arb_count", 32'(g), 32'd10);
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (5) @(negedge hclk);

        // Reset asserted during the address phase.
        ls_req   = 1'b1;
        ls_addr  = 32'hB000_0040;
        ls_func3 = 3'b000;
        hready   = 1'b0;
        @(negedge hclk);
        chk("rstmid_before", 32'(htrans), 32'h2);
        hresetn = 1'b0;
        #1;
        chk("rstmid_htrans", 32'(htrans), 32'h0);
        chk("rstmid_hsize", 32'(hsize), 32'h2);
        chk("rstmid_haddr", haddr, 32'h0);
        ls_req = 1'b0;
        hready = 1'b1;
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            chk("rstmid_nodone", 32'({ls_done, if_done, htrans}), 32'h0);
        end

        // Randomized single transfers.
        for (int it = 0; it < 40; it++) begin
            r_if = ($urandom_range(0, 3) == 0);
            r_wr = 1'($urandom_range(0, 1));
            r_f3 = f3_tab[$urandom_range(0, 4)];
            if (r_wr) r_f3 = r_f3 & 3'b011;
            r_addr = (r_if ? 32'hA000_0000 : 32'hB000_0000) | ($urandom & 32'h00FF_FFFC);
            if ($urandom_range(0, 3) == 0) r_addr = r_addr | 32'($urandom_range(0, 3));
            else if (!r_if && m_size(r_f3) == 3'b000) r_addr = r_addr | 32'($urandom_range(0, 3));
            else if (!r_if && m_size(r_f3) == 3'b001) r_addr = r_addr | 32'(2 * $urandom_range(0, 1));
            xfer(r_if, r_wr, r_f3, r_addr, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
